// File: rtl/vga_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen_if
//   Bundles the video-path signals of the pattern generator.
//   Timing inputs : hvis_in, vvis_in, hsync_in (active-low), vsync_in (active-low)
//   Button input  : mode_btn (raw, asynchronous, 1 = pressed)
//   Outputs       : hsync_out, vsync_out (3-cycle delayed syncs),
//                   rgb [7:0] (RGB332: [2:0] red, [5:3] green, [7:6] blue),
//                   mode [1:0] (currently displayed pattern)
//   master: the upstream timing source / bench; slave: the pattern generator.
// ---------------------------------------------------------------------------
interface vga_pattern_gen_if;
    logic       hvis_in;
    logic       vvis_in;
    logic       hsync_in;
    logic       vsync_in;
    logic       mode_btn;
    logic       hsync_out;
    logic       vsync_out;
    logic [7:0] rgb;
    logic [1:0] mode;

    modport master (
        output hvis_in, vvis_in, hsync_in, vsync_in, mode_btn,
        input  hsync_out, vsync_out, rgb, mode
    );

    modport slave (
        input  hvis_in, vvis_in, hsync_in, vsync_in, mode_btn,
        output hsync_out, vsync_out, rgb, mode
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//   Pixel source placed right after the VGA timing generator. Tracks pixel
//   coordinates from the visible-region flags and drives RGB332 with one of
//   four test patterns: colour bars, checkerboard, gradient, bouncing box.
//   Syncs travel through the same 3-stage pipeline as the colour data.
//   A debounced push-button steps the pattern; the step is applied only on
//   entry into vertical blanking.
//
//   Ports:
//     pclk  - pixel clock, all logic on posedge
//     rstn  - asynchronous active-low reset
//     bus   - vga_pattern_gen_if.slave (timing in, button in, video out, mode)
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int H_VIS      = 640,
    parameter int V_VIS      = 480,
    parameter int BAR_W      = 80,
    parameter int BOX        = 32,
    parameter int DEB_CYCLES = 360000
) (
    input  logic              pclk,
    input  logic              rstn,
    vga_pattern_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_BOX   = 2'd3
    } mode_e;

    localparam int CW = 11;                      // coordinate width
    localparam int BW = $clog2(BAR_W);
    localparam int DW = $clog2(DEB_CYCLES);

    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic [CW-1:0] BX_MAX   = CW'(H_VIS - BOX);
    localparam logic [CW-1:0] BY_MAX   = CW'(V_VIS - BOX);
    localparam logic [CW-1:0] BOX_LEN  = CW'(BOX);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0] BAR_RGB [8] = '{8'hFF, 8'h3F, 8'hF8, 8'h38,
                                           8'hC7, 8'h07, 8'hC0, 8'h00};

    // Stage 1 and edge-detect history
    logic s1_hvis, s1_vvis, s1_hsync, s1_vsync;
    logic hvis_d, vvis_d;

    // Coordinate tracking
    logic [CW-1:0] x_cnt, y_cnt;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic [7:0]    frame_cnt;

    // Bouncing box
    logic [CW-1:0] box_x, box_y;
    logic          box_dx_neg, box_dy_neg;

    // Button path
    logic          btn_meta, btn_sync, btn_deb, pending;
    logic [DW-1:0] deb_cnt;
    logic          deb_rise;
    mode_e         mode_q;

    // Stages 2 and 3
    logic [7:0] pix_rgb, s2_rgb, rgb_q;
    logic       s2_hsync, s2_vsync, hsync_q, vsync_q;

    logic de1, line_end, frame_evt, in_box;

    assign de1       = s1_hvis & s1_vvis;
    assign line_end  = hvis_d & ~s1_hvis;
    assign frame_evt = vvis_d & ~s1_vvis;       // entry into vertical blanking

    // ---------------- Stage 1 ----------------
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse pipeline stages.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            s1_hvis  <= 1'b0;
            s1_vvis  <= 1'b0;
            s1_hsync <= 1'b1;
            s1_vsync <= 1'b1;
            hvis_d   <= 1'b0;
            vvis_d   <= 1'b0;
        end else begin
            s1_hvis  <= bus.hvis_in;
            s1_vvis  <= bus.vvis_in;
            s1_hsync <= bus.hsync_in;
            s1_vsync <= bus.vsync_in;
            hvis_d   <= s1_hvis;
            vvis_d   <= s1_vvis;
        end
    end

    // x_cnt is the column of the pixel currently in stage 1; the bar index
    // follows it with a modulo-BAR_W sub-counter instead of a divider.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            x_cnt   <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            y_cnt   <= '0;
        end else begin
            if (!s1_hvis) begin
                x_cnt   <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
            end else begin
                x_cnt <= x_cnt + 1'b1;
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 1'b1;
                end else begin
                    bar_cnt <= bar_cnt + 1'b1;
                end
            end

            if (!s1_vvis)
                y_cnt <= '0;
            else if (line_end)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    // Frame counter and box motion; the box moves in every mode so its
    // position stays continuous across pattern switches.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt  <= '0;
            box_x      <= '0;
            box_y      <= '0;
            box_dx_neg <= 1'b0;
            box_dy_neg <= 1'b0;
        end else if (frame_evt) begin
            frame_cnt <= frame_cnt + 1'b1;

            // Hitting a wall flips direction and already steps back this frame.
            if (!box_dx_neg) begin
                if (box_x == BX_MAX) begin
                    box_dx_neg <= 1'b1;
                    box_x      <= box_x - 1'b1;
                end else begin
                    box_x <= box_x + 1'b1;
                end
            end else begin
                if (box_x == '0) begin
                    box_dx_neg <= 1'b0;
                    box_x      <= box_x + 1'b1;
                end else begin
                    box_x <= box_x - 1'b1;
                end
            end

            if (!box_dy_neg) begin
                if (box_y == BY_MAX) begin
                    box_dy_neg <= 1'b1;
                    box_y      <= box_y - 1'b1;
                end else begin
                    box_y <= box_y + 1'b1;
                end
            end else begin
                if (box_y == '0) begin
                    box_dy_neg <= 1'b0;
                    box_y      <= box_y + 1'b1;
                end else begin
                    box_y <= box_y - 1'b1;
                end
            end
        end
    end

    // ---------------- Button: synchroniser + debounce ----------------
    // The debounced level flips on the DEB_CYCLES-th consecutive cycle that
    // the synchronised input disagrees with it; any agreement reloads.
    assign deb_rise = btn_sync & ~btn_deb & (deb_cnt == DEB_LAST);

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_deb  <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_meta <= bus.mode_btn;
            btn_sync <= btn_meta;
            if (btn_sync == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                btn_deb <= btn_sync;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // A press only arms the step; it lands in vertical blanking so a frame
    // is never drawn with two patterns. A press landing on the same cycle
    // as a frame event re-arms and is applied at the following event.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            pending <= 1'b0;
            mode_q  <= MODE_BARS;
        end else begin
            if (frame_evt && pending) begin
                mode_q  <= mode_e'(mode_q + 2'd1);
                pending <= 1'b0;
            end
            if (deb_rise)
                pending <= 1'b1;
        end
    end

    // ---------------- Stage 2: colour ----------------
    assign in_box = (x_cnt >= box_x) && (x_cnt < box_x + BOX_LEN) &&
                    (y_cnt >= box_y) && (y_cnt < box_y + BOX_LEN);

    // NOTE: combinational blocks assign a default first so no path leaves
    // the output unassigned, which would infer a latch.
    always_comb begin
        pix_rgb = 8'h00;
        unique case (mode_q)
            MODE_BARS:  pix_rgb = BAR_RGB[bar_idx];
            MODE_CHECK: pix_rgb = (x_cnt[5] ^ y_cnt[5]) ? 8'hFF : 8'h00;
            MODE_GRAD:  pix_rgb = {frame_cnt[7:6], y_cnt[8:6], x_cnt[8:6]};
            MODE_BOX:   pix_rgb = in_box ? 8'hFF : 8'hC0;
        endcase
    end

    // ---------------- Stages 2 and 3: registers ----------------
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            s2_rgb   <= 8'h00;
            s2_hsync <= 1'b1;
            s2_vsync <= 1'b1;
            rgb_q    <= 8'h00;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
        end else begin
            s2_rgb   <= de1 ? pix_rgb : 8'h00;
            s2_hsync <= s1_hsync;
            s2_vsync <= s1_vsync;
            rgb_q    <= s2_rgb;
            hsync_q  <= s2_hsync;
            vsync_q  <= s2_vsync;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.hsync_out = hsync_q;
    assign bus.vsync_out = vsync_q;
    assign bus.mode      = mode_q;

endmodule
